// File: rtl/fpmul_pkg.sv
// rtl/fpmul_pkg.sv - shared state, flag and IEEE-754 field definitions for the FPMul issue queue
package fpmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Flag vector ordering shared with FPMul: {OF,UF,NanF,InfF,DNF,ZF}
    localparam int FLG_OF   = 5;
    localparam int FLG_UF   = 4;
    localparam int FLG_NANF = 3;
    localparam int FLG_INFF = 2;
    localparam int FLG_DNF  = 1;
    localparam int FLG_ZF   = 0;

    localparam logic [31:0] QNAN       = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_ONES   = 8'hFF;
    localparam logic [5:0]  FLAGS_NAN  = 6'b1 << FLG_NANF;
    localparam logic [5:0]  FLAGS_ZERO = 6'b1 << FLG_ZF;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } operand_t;

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    function automatic logic is_inf_nan(input logic [31:0] x);
        return x[30:23] == EXP_ONES;
    endfunction

    // A signed zero times any finite value is a signed zero; Inf/NaN must still go to FPMul.
    function automatic logic zero_bypass(input operand_t op);
        return (is_zero(op.a) && !is_inf_nan(op.b)) || (is_zero(op.b) && !is_inf_nan(op.a));
    endfunction

endpackage

// File: rtl/fpmul_issue_queue_if.sv
// rtl/fpmul_issue_queue_if.sv - operand stream, FPMul handshake and result stream bundle
interface fpmul_issue_queue_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done;
    logic [31:0] mul_p;
    logic [5:0]  mul_flags;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic [5:0]  out_flags;

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_p, mul_flags, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_p, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_p, mul_flags, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_p, out_flags
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO, DEPTH a power of two
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fpmul_issue_queue.sv
// rtl/fpmul_issue_queue.sv - streaming sequencer in front of FPMul; FPMUL_ZERO_BYPASS_EN enables zero-operand bypass
module fpmul_issue_queue
    import fpmul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    fpmul_issue_queue_if.slave bus,
    output logic               busy_o,
    output logic               timeout_err_o
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mul_a_q, mul_a_d;
    logic [31:0]   mul_b_q, mul_b_d;
    logic [31:0]   out_p_q, out_p_d;
    logic [5:0]    out_flags_q, out_flags_d;
    logic          out_valid_q, out_valid_d;
    logic          terr_q, terr_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    operand_t      fifo_wdata, head;

    assign fifo_wdata = '{a: bus.in_a, b: bus.in_b};
    assign fifo_push  = bus.in_valid && !fifo_full;

    sync_fifo #(
        .WIDTH ($bits(operand_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_p_q     <= '0;
            out_flags_q <= '0;
            out_valid_q <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_p_q     <= out_p_d;
            out_flags_q <= out_flags_d;
            out_valid_q <= out_valid_d;
            terr_q      <= terr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_p_d     = out_p_q;
        out_flags_d = out_flags_q;
        out_valid_d = out_valid_q;
        terr_d      = terr_q;

        unique case (state_q)
            IDLE: ;
            // Done is not looked at here: it may still be high from the previous product.
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    out_p_d     = bus.mul_p;
                    out_flags_d = bus.mul_flags;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d      = 1'b1;
                    out_p_d     = QNAN;
                    out_flags_d = FLAGS_NAN;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop from IDLE or HOLD overrides the case above and launches the head pair.
        if (fifo_pop) begin
`ifdef FPMUL_ZERO_BYPASS_EN
            if (zero_bypass(head)) begin
                out_p_d     = {head.a[31] ^ head.b[31], 31'd0};
                out_flags_d = FLAGS_ZERO;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                mul_a_d = head.a;
                mul_b_d = head.b;
                state_d = ISSUE;
            end
`else
            mul_a_d = head.a;
            mul_b_d = head.b;
            state_d = ISSUE;
`endif
        end
    end

    always_comb begin
        fifo_pop = !fifo_empty && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
        busy_o   = (state_q != IDLE) || !fifo_empty;
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.mul_start  = (state_q == ISSUE);
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_p      = out_p_q;
    assign bus.out_flags  = out_flags_q;
    assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_fpmul_issue_queue.sv
// tb/tb_fpmul_issue_queue.sv - directed bench for fpmul_issue_queue with a behavioural FPMul responder
module tb_fpmul_issue_queue;

    localparam int DEPTH = 4;
    localparam int TMO   = 20;
`ifdef FPMUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, terr;

    fpmul_issue_queue_if bus();

    fpmul_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .busy_o        (busy),
        .timeout_err_o (terr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed products: {flags, p}
    function automatic logic [37:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40000000}: return {6'b000000, 32'h40800000};
            {32'h3F800000, 32'h40400000}: return {6'b000000, 32'h40400000};
            {32'h40000000, 32'h3F000000}: return {6'b000000, 32'h3F800000};
            {32'hBF800000, 32'h3FC00000}: return {6'b000000, 32'hBFC00000};
            {32'h80000000, 32'h40000000}: return {6'b000001, 32'h80000000};
            {32'h00000000, 32'h7F800000}: return {6'b001000, 32'h7FC00000};
            {32'h7F000000, 32'h7F000000}: return {6'b100100, 32'h7F800000};
            default: return (b == 32'h3F800000) ? {6'b000000, a} : {6'b111111, 32'hDEADBEEF};
        endcase
    endfunction

    logic        stub_done, stub_dead, force_done;
    logic [31:0] stub_p;
    logic [5:0]  stub_f;
    int          stub_cnt, stub_lat, n_start;

    // Done is a level that stays high until the next Start, like FPMul.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
            stub_p    <= '0;
            stub_f    <= '0;
        end else if (bus.mul_start) begin
            stub_done      <= 1'b0;
            stub_cnt       <= stub_dead ? 0 : stub_lat;
            {stub_f, stub_p} <= fmul_ref(bus.mul_a, bus.mul_b);
        end else if (stub_cnt == 1) begin
            stub_done <= 1'b1;
            stub_cnt  <= 0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.mul_start) n_start <= n_start + 1;
    end

    assign bus.mul_done  = stub_done | force_done;
    assign bus.mul_p     = stub_done ? stub_p : 32'hDEADBEEF;
    assign bus.mul_flags = stub_done ? stub_f : 6'b111111;

    logic [31:0] got_p [$];
    logic [5:0]  got_f [$];
    logic        start_after [$];
    logic [31:0] ints [6];

    task automatic push_one(input logic [31:0] a, input logic [31:0] b);
        check_eq("push_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k, output logic pd);
        int i;
        pd = 1'b0;
        for (i = 0; i < 100; i++) begin
            if (bus.out_valid) break;
            pd = bus.mul_done;
            @(negedge clk);
        end
        k = i;
        check_eq("wait_valid_bound", i < 100, 1'b1);
    endtask

    task automatic drain(input int n);
        int  got = 0;
        logic rec;
        got_p.delete();
        got_f.delete();
        start_after.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            rec = 1'b0;
            if (bus.out_valid) begin
                got_p.push_back(bus.out_p);
                got_f.push_back(bus.out_flags);
                got++;
                rec = 1'b1;
            end
            @(negedge clk);
            if (rec) start_after.push_back(bus.mul_start);
            if (got == n) break;
        end
        bus.out_ready = 1'b0;
        check_eq("drain_count", got, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat, acc, s0, k, waited;
        logic pd, pv, seen, stale;

        ints = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        stub_dead     = 1'b0;
        stub_lat      = 3;
        force_done    = 1'b0;
        n_start       = 0;

        repeat (3) @(negedge clk);
        check_eq("rst_mul_start", bus.mul_start, 1'b0);
        check_eq("rst_mul_a", bus.mul_a, 32'h0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_p", bus.out_p, 32'h0);
        check_eq("rst_out_flags", bus.out_flags, 6'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_terr", terr, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);

        // 2.0 x 2.0: Start two cycles after push, result held until accepted
        push_one(32'h40000000, 32'h40000000);
        check_eq("t1_start_early", bus.mul_start, 1'b0);
        check_eq("t1_busy", busy, 1'b1);
        @(negedge clk);
        check_eq("t1_start", bus.mul_start, 1'b1);
        check_eq("t1_mul_a", bus.mul_a, 32'h40000000);
        check_eq("t1_mul_b", bus.mul_b, 32'h40000000);
        @(negedge clk);
        check_eq("t1_start_pulse", bus.mul_start, 1'b0);
        check_eq("t1_mul_a_stable", bus.mul_a, 32'h40000000);
        wait_valid(lat, pd);
        check_eq("t1_latency", lat, 4);
        check_eq("t1_done_to_valid", pd, 1'b1);
        check_eq("t1_out_p", bus.out_p, 32'h40800000);
        check_eq("t1_out_flags", bus.out_flags, 6'b000000);
        repeat (3) @(negedge clk);
        check_eq("t1_hold_valid", bus.out_valid, 1'b1);
        check_eq("t1_hold_p", bus.out_p, 32'h40800000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("t1_valid_drop", bus.out_valid, 1'b0);
        check_eq("t1_idle_busy", busy, 1'b0);

        // Flag capture
        push_one(32'h7F000000, 32'h7F000000);
        drain(1);
        check_eq("fl_p", got_p[0], 32'h7F800000);
        check_eq("fl_flags", got_f[0], 6'b100100);

        // Back-to-back: three pairs, results in order, Start straight from HOLD
        push_one(32'h3F800000, 32'h40400000);
        push_one(32'h40000000, 32'h3F000000);
        push_one(32'hBF800000, 32'h3FC00000);
        drain(3);
        check_eq("t2_p0", got_p[0], 32'h40400000);
        check_eq("t2_p1", got_p[1], 32'h3F800000);
        check_eq("t2_p2", got_p[2], 32'hBFC00000);
        check_eq("t2_b2b0", start_after[0], 1'b1);
        check_eq("t2_b2b1", start_after[1], 1'b1);

        // Capacity: DEPTH queued plus one in flight
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = ints[acc];
            bus.in_b     = 32'h3F800000;
            if (bus.in_ready) begin
                @(negedge clk);
                acc++;
            end else begin
                @(negedge clk);
            end
            if (acc == 6) break;
        end
        check_eq("t3_accepted", acc, DEPTH + 1);
        check_eq("t3_in_ready_low", bus.in_ready, 1'b0);
        wait_valid(lat, pd);
        check_eq("t3_in_ready_hold", bus.in_ready, 1'b0);
        check_eq("t3_first_p", bus.out_p, 32'h3F800000);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("t3_in_ready_free", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain(5);
        for (int i = 0; i < 5; i++) check_eq($sformatf("t3_p%0d", i + 1), got_p[i], ints[i + 1]);

        // Timeout: FPMul never answers
        stub_dead = 1'b1;
        push_one(32'h40400000, 32'h40400000);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mul_start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("t4_start_seen", seen, 1'b1);
        waited = 0;
        pv = 1'b0;
        for (k = 1; k < 200; k++) begin
            pv = bus.out_valid;
            @(negedge clk);
            if (terr) break;
        end
        waited = k;
        check_eq("t4_timeout_cycles", waited, TMO + 1);
        check_eq("t4_no_early_valid", pv, 1'b0);
        check_eq("t4_out_valid", bus.out_valid, 1'b1);
        check_eq("t4_out_p", bus.out_p, 32'h7FC00000);
        check_eq("t4_out_flags", bus.out_flags, 6'b001000);
        drain(1);
        stub_dead = 1'b0;
        check_eq("t4_terr_sticky", terr, 1'b1);

        // Done outside WAIT is ignored
        force_done = 1'b1;
        repeat (2) @(negedge clk);
        force_done = 1'b0;
        check_eq("t5_done_idle_valid", bus.out_valid, 1'b0);
        check_eq("t5_done_idle_busy", busy, 1'b0);

        // Reset mid-WAIT abandons everything
        stub_lat = 10;
        push_one(32'h40000000, 32'h40000000);
        push_one(32'h3F800000, 32'h40400000);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_start", bus.mul_start, 1'b0);
        check_eq("t6_rst_mul_a", bus.mul_a, 32'h0);
        check_eq("t6_rst_valid", bus.out_valid, 1'b0);
        check_eq("t6_rst_terr", terr, 1'b0);
        check_eq("t6_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        stub_lat = 3;
        stale    = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stale = stale | bus.out_valid | bus.mul_start | busy;
        end
        check_eq("t6_no_stale", stale, 1'b0);
        push_one(32'h40000000, 32'h3F000000);
        drain(1);
        check_eq("t6_after_p", got_p[0], 32'h3F800000);
        check_eq("t6_after_busy", busy, 1'b0);

        // Signed-zero operand: bypassed when enabled, otherwise through FPMul
        s0 = n_start;
        push_one(32'h80000000, 32'h40000000);
        check_eq("t7_n1_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check_eq("t7_valid_2cyc", bus.out_valid, BYP);
        check_eq("t7_start_2cyc", bus.mul_start, !BYP);
        drain(1);
        check_eq("t7_p", got_p[0], 32'h80000000);
        check_eq("t7_flags", got_f[0], 6'b000001);
        check_eq("t7_starts", n_start - s0, BYP ? 0 : 1);

        s0 = n_start;
        push_one(32'h00000000, 32'h7F800000);
        drain(1);
        check_eq("t7_zinf_p", got_p[0], 32'h7FC00000);
        check_eq("t7_zinf_flags", got_f[0], 6'b001000);
        check_eq("t7_zinf_starts", n_start - s0, 1);

        s0 = n_start;
        push_one(32'h40000000, 32'h40000000);
        push_one(32'h80000000, 32'h40000000);
        push_one(32'h3F800000, 32'h40400000);
        drain(3);
        check_eq("t7_ord0", got_p[0], 32'h40800000);
        check_eq("t7_ord1", got_p[1], 32'h80000000);
        check_eq("t7_ord2", got_p[2], 32'h40400000);
        check_eq("t7_ord_starts", n_start - s0, BYP ? 2 : 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
